mul_share_ctrl: RTL and testbench
=================================

# mul_share_ctrl

Controller and round-robin arbiter that shares one repeated-addition multiplier datapath (A register, product register P, down-counter B, adder, zero-detect) between two requesters. It arbitrates requests and steers the selected operands onto the datapath input bus. It sequences the load, clear, add and decrement controls. When the datapath's zero flag ends the loop, it returns the product to the winning requester with a one-cycle done pulse. It sits between the requesting blocks and the multiplier datapath and replaces the datapath's single-user controller.

## Interface
- W, 16, operand/product width; must match the datapath width.
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  synchronous active-high reset; one clock, synchronous reset, active-high.
- req  in  2  level request per requester; held high until that requester's done bit pulses.
- a0, b0  in  W  requester 0 multiplicand/multiplier; stable while req[0] is high.
- a1, b1  in  W  requester 1 operands; stable while req[1] is high.
- done  out  2  one-cycle pulse on the served requester's bit.
- result  out  W  product (mod 2^W); valid when done≠0; holds value until next done.
- busy  out  1  high in every state except IDLE.
- gnt_id  out  1  index of served requester; meaningful while busy.
- dp_data  out  W  datapath input bus.
- ld_a, ld_b, ld_p, clr_p, dec_b  out  1 each  datapath controls (A load, B load, P load of P+A, P clear, B decrement).
- eqz  in  1  datapath combinational flag, high when B==0.
- p_in  in  W  datapath product register output.

## Operation
- States: IDLE, LOAD_A, LOAD_B, RUN, DONE.
- IDLE:
  - all datapath controls 0; dp_data=0.
  - If any req bit is high: latch the grant into gnt_id, update the last-served pointer, go to LOAD_A.
- Arbitration, single request: that requester wins.
- Arbitration, req==2'b11: the requester that was not last served wins.
- Last-served pointer resets to 1, so requester 0 wins the first tie after reset.
- LOAD_A: ld_a=1, dp_data = a of the granted requester; go to LOAD_B.
- LOAD_B: ld_b=1, clr_p=1, dp_data = b of the granted requester; go to RUN.
- RUN:
  - ld_p = dec_b = ~eqz.
  - If eqz: capture result <= p_in at this edge and go to DONE; otherwise stay in RUN.
- DONE: done[gnt_id]=1, all datapath controls 0; go to IDLE.
- Control outputs are Moore decodes of state.
- No new grant is made in DONE. A req still high in the following IDLE cycle is treated as a new request.
- Arithmetic: product is a·b mod 2^W.
- b=0 yields 0 with no ld_p pulses.
- Protocol violations:
  - req dropped mid-operation: the operation completes and done still pulses.
  - Operands changed after LOAD_B: no effect on the result.
  - Operands changed during LOAD_A/LOAD_B: the sampled value is used; this is undefined for the requester.
- Reset, at any state including mid-RUN, at the next edge:
  - state IDLE;
  - done=0, busy=0, gnt_id=0, result=0, dp_data=0;
  - all datapath controls 0;
  - pointer=1.
  - No done is emitted for the aborted operation.

## Timing
- Cycle 0 = IDLE cycle in which req is sampled high.
- Cycle 1 = LOAD_A; cycle 2 = LOAD_B; cycles 3 .. 3+b = RUN (b+1 cycles); cycle 4+b = DONE.
- Latency from request sample to done pulse = b+4 cycles.
- ld_p and dec_b are high for exactly b cycles.
- result and done change at the same edge.
- Next grant is possible at cycle 5+b (IDLE).
- A requester that deasserts req on the edge ending its done cycle is not re-granted.
- Worst case at W=16: b=65535 gives RUN = 65536 cycles. No timeout.
- busy rises at the edge ending cycle 0 and falls at the edge ending DONE.

## Test plan
- Single request: req[0]=1, a0=17, b0=5 from idle → LOAD_A/LOAD_B at cycles 1/2; ld_p high 5 cycles; done=2'b01 at cycle 9; result=85; busy low at cycle 10.
- Zero multiplier: req[1]=1, a1=1234, b1=0 → ld_p never high; done=2'b10 at cycle 4; result=0.
- Tie after reset: req=2'b11, a0=3,b0=4, a1=6,b1=7 → requester 0 served first (result 12, done[0]). Requester 1 granted at the next IDLE (result 42, done[1]). A third simultaneous round → requester 0 again (alternation).
- Overflow: a0=300, b0=300 → result=24464 (90000 mod 65536); done[0] at cycle 304.
- Reset mid-RUN: a0=10, b0=20, rst=1 for one cycle during RUN → next cycle all outputs 0, state IDLE, no done pulse. A fresh request a0=7, b0=2 → result 14 at cycle 6.
- Held req: requester 0 keeps req high after done → re-granted in the following IDLE cycle; requester 1 arriving with it wins that tie.

Source files
------------

// File: rtl/mul_share_ctrl_if.sv
// Bundle between two requesters, the shared multiplier datapath and the sharing controller.
// master = controller side, slave = requester/datapath side.
interface mul_share_ctrl_if #(
    parameter int W = 16
);
    logic [1:0]   req;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic [1:0]   done;
    logic [W-1:0] result;
    logic         busy;
    logic         gnt_id;
    logic [W-1:0] dp_data;
    logic         ld_a;
    logic         ld_b;
    logic         ld_p;
    logic         clr_p;
    logic         dec_b;
    logic         eqz;
    logic [W-1:0] p_in;

    modport master (
        input  req, a0, b0, a1, b1, eqz, p_in,
        output done, result, busy, gnt_id, dp_data, ld_a, ld_b, ld_p, clr_p, dec_b
    );

    modport slave (
        output req, a0, b0, a1, b1, eqz, p_in,
        input  done, result, busy, gnt_id, dp_data, ld_a, ld_b, ld_p, clr_p, dec_b
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin controller sharing one repeated-addition multiplier between two requesters.
// Latency b+4 cycles from request sample to done pulse; requests are level-held, no grant outside IDLE.
module mul_share_ctrl #(
    parameter int W = 16
) (
    input  logic               clk,
    input  logic               rst,
    mul_share_ctrl_if.master   bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        RUN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic           gnt_q, gnt_d;
    logic           last_q, last_d;
    logic [W-1:0]   result_q, result_d;
    logic           win;

    logic [1:0]     done_o;
    logic [W-1:0]   dp_data_o;
    logic           ld_a_o, ld_b_o, ld_p_o, clr_p_o, dec_b_o;

    // On a tie the requester not served last wins; a lone request always wins.
    always_comb begin
        if (bus.req == 2'b11) begin
            win = ~last_q;
        end else begin
            win = bus.req[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        result_d  = result_q;
        done_o    = 2'b00;
        dp_data_o = '0;
        ld_a_o    = 1'b0;
        ld_b_o    = 1'b0;
        ld_p_o    = 1'b0;
        clr_p_o   = 1'b0;
        dec_b_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    gnt_d   = win;
                    last_d  = win;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                ld_a_o    = 1'b1;
                dp_data_o = gnt_q ? bus.a1 : bus.a0;
                state_d   = LOAD_B;
            end
            LOAD_B: begin
                ld_b_o    = 1'b1;
                clr_p_o   = 1'b1;
                dp_data_o = gnt_q ? bus.b1 : bus.b0;
                state_d   = RUN;
            end
            RUN: begin
                ld_p_o  = ~bus.eqz;
                dec_b_o = ~bus.eqz;
                if (bus.eqz) begin
                    result_d = bus.p_in;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done_o[gnt_q] = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.done    = done_o;
    assign bus.result  = result_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.gnt_id  = gnt_q;
    assign bus.dp_data = dp_data_o;
    assign bus.ld_a    = ld_a_o;
    assign bus.ld_b    = ld_b_o;
    assign bus.ld_p    = ld_p_o;
    assign bus.clr_p   = clr_p_o;
    assign bus.dec_b   = dec_b_o;
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a behavioural repeated-addition datapath attached.
module tb_mul_share_ctrl;
    localparam int W = 16;

    logic clk;
    logic rst;

    mul_share_ctrl_if #(.W(W)) bus ();

    mul_share_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared datapath: A, P, down-counter B
    logic [W-1:0] a_reg, b_reg, p_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            p_reg <= '0;
        end else begin
            if (bus.ld_a)       a_reg <= bus.dp_data;
            if (bus.ld_b)       b_reg <= bus.dp_data;
            else if (bus.dec_b) b_reg <= b_reg - 1'b1;
            if (bus.clr_p)      p_reg <= '0;
            else if (bus.ld_p)  p_reg <= p_reg + a_reg;
        end
    end
    assign bus.eqz  = (b_reg == '0);
    assign bus.p_in = p_reg;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Entered at the negedge of an IDLE cycle with req already driven; leaves at the negedge
    // of the IDLE cycle after DONE with req set to req_after.
    task automatic run_op(input logic [1:0] req_after, input logic exp_gnt,
                          input logic [W-1:0] exp_a, input logic [W-1:0] exp_b,
                          input logic [W-1:0] exp_res);
        int cyc;
        int nld;
        int ndec;
        @(negedge clk);
        chk("loada_ctl", {bus.ld_a, bus.ld_b, bus.clr_p, bus.ld_p, bus.dec_b}, 5'b10000);
        chk("loada_dat", bus.dp_data, exp_a);
        chk("busy", bus.busy, 1);
        chk("gnt_id", bus.gnt_id, exp_gnt);
        @(negedge clk);
        chk("loadb_ctl", {bus.ld_a, bus.ld_b, bus.clr_p, bus.ld_p, bus.dec_b}, 5'b01100);
        chk("loadb_dat", bus.dp_data, exp_b);
        cyc  = 3;
        nld  = 0;
        ndec = 0;
        @(negedge clk);
        while (bus.done == 2'b00 && cyc < 70000) begin
            nld  += int'(bus.ld_p);
            ndec += int'(bus.dec_b);
            @(negedge clk);
            cyc++;
        end
        chk("done_cycle", cyc, 4 + int'(exp_b));
        chk("done_bits", bus.done, exp_gnt ? 2'b10 : 2'b01);
        chk("result", bus.result, exp_res);
        chk("ld_p_count", nld, exp_b);
        chk("dec_b_count", ndec, exp_b);
        chk("done_ctl", {bus.busy, bus.ld_a, bus.ld_b, bus.clr_p, bus.ld_p, bus.dec_b}, 6'b100000);
        bus.req = req_after;
        @(negedge clk);
        chk("idle_out", {bus.busy, bus.done, bus.ld_a, bus.ld_b, bus.clr_p, bus.ld_p, bus.dec_b}, 0);
        chk("idle_dat", bus.dp_data, 0);
        chk("result_hold", bus.result, exp_res);
    endtask

    initial begin
        logic seen;
        rst    = 1'b1;
        bus.req = 2'b00;
        bus.a0 = '0;
        bus.b0 = '0;
        bus.a1 = '0;
        bus.b1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out", {bus.busy, bus.done, bus.gnt_id, bus.ld_a, bus.ld_b,
                        bus.clr_p, bus.ld_p, bus.dec_b}, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_dat", bus.dp_data, 0);

        // Single request
        bus.a0 = 16'd17; bus.b0 = 16'd5; bus.req = 2'b01;
        run_op(2'b00, 1'b0, 16'd17, 16'd5, 16'd85);

        // Zero multiplier
        bus.a1 = 16'd1234; bus.b1 = 16'd0; bus.req = 2'b10;
        run_op(2'b00, 1'b1, 16'd1234, 16'd0, 16'd0);

        // Overflow wraps mod 2^16
        bus.a0 = 16'd300; bus.b0 = 16'd300; bus.req = 2'b01;
        run_op(2'b00, 1'b0, 16'd300, 16'd300, 16'd24464);

        // Reset mid-RUN: last served becomes 0, reset must restore pointer to 1
        bus.a0 = 16'd10; bus.b0 = 16'd20; bus.req = 2'b01;
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        bus.req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out", {bus.busy, bus.done, bus.gnt_id, bus.ld_a, bus.ld_b,
                            bus.clr_p, bus.ld_p, bus.dec_b}, 0);
        chk("mid_rst_result", bus.result, 0);
        chk("mid_rst_dat", bus.dp_data, 0);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            seen = seen | (|bus.done) | bus.busy;
        end
        chk("no_done_after_rst", seen, 0);

        // Tie right after reset: requester 0 must win, then requester 1
        bus.a0 = 16'd7; bus.b0 = 16'd2; bus.a1 = 16'd1; bus.b1 = 16'd1; bus.req = 2'b11;
        run_op(2'b10, 1'b0, 16'd7, 16'd2, 16'd14);
        run_op(2'b00, 1'b1, 16'd1, 16'd1, 16'd1);

        // Tie alternation: last served was 1 so requester 0 wins
        bus.a0 = 16'd3; bus.b0 = 16'd4; bus.a1 = 16'd6; bus.b1 = 16'd7; bus.req = 2'b11;
        run_op(2'b10, 1'b0, 16'd3, 16'd4, 16'd12);
        run_op(2'b11, 1'b1, 16'd6, 16'd7, 16'd42);
        run_op(2'b00, 1'b0, 16'd3, 16'd4, 16'd12);

        // Held request is re-granted; a tie with it then goes to requester 1
        bus.a0 = 16'd5; bus.b0 = 16'd3; bus.a1 = 16'd2; bus.b1 = 16'd9; bus.req = 2'b01;
        run_op(2'b01, 1'b0, 16'd5, 16'd3, 16'd15);
        run_op(2'b11, 1'b0, 16'd5, 16'd3, 16'd15);
        run_op(2'b01, 1'b1, 16'd2, 16'd9, 16'd18);
        run_op(2'b00, 1'b0, 16'd5, 16'd3, 16'd15);

        // Requester drops req mid-operation: still completes
        bus.a1 = 16'd9; bus.b1 = 16'd4; bus.req = 2'b10;
        @(negedge clk);
        bus.req = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done == 2'b10 && bus.result == 16'd36) seen = 1'b1;
        end
        chk("drop_req_done", seen, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
